imem_loader: RTL

Boot-time program loader that sits directly upstream of the RV32I core's instruction memory. It accepts a byte stream (length header followed by little-endian instruction words), writes each assembled word into the instruction memory write port, and holds the core in reset until the whole program is in place. It replaces hierarchical memory preloading, so the same program image can be delivered by a bench, a UART receiver or a debug port.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/imem_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data width, instruction-word type and the
// boot loader's state encoding.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;

    typedef enum logic [1:0] {
        S_LEN0 = 2'd0,
        S_LEN1 = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } load_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed little-endian byte stream into
// instruction-memory writes and holds the core in reset until the image is in.
module imem_loader
    import rv32i_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output instr_t            mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              overflow,
    output load_state_e       dbg_state
);

    // Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
    // rx_ready depends only on the current state, never on rx_valid.

    load_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    instr_t            mem_wdata_q, mem_wdata_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              accept;

    assign rx_ready   = (state_q != S_DONE);
    assign accept     = rx_valid && rx_ready;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign overflow   = overflow_q;
    assign done       = done_q;
    assign core_reset = !done_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_LEN0: begin
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    cnt_d[15:8] = rx_data;
                    word_idx_d  = 16'd0;
                    byte_idx_d  = 2'd0;
                    state_d     = ({rx_data, cnt_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx_q == 2'd3) begin
                        mem_wdata_d = {rx_data, asm_q};
                        mem_addr_d  = word_idx_q[ADDR_W-1:0];
                        // Words beyond the memory are swallowed so the stream stays aligned.
                        if ({1'b0, word_idx_q} < 17'(DEPTH)) begin
                            mem_we_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        word_idx_d = word_idx_q + 16'd1;
                        byte_idx_d = 2'd0;
                        if (word_idx_q == cnt_q - 16'd1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        case (byte_idx_q)
                            2'd0:    asm_d[7:0]   = rx_data;
                            2'd1:    asm_d[15:8]  = rx_data;
                            default: asm_d[23:16] = rx_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                if (load_start) begin
                    state_d    = S_LEN0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = S_LEN0;
        endcase
        // Release lags entry to S_DONE by one cycle so the last write lands while
        // the core is still held in reset; re-entering a load drops it at once.
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_LEN0;
            cnt_q       <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

endmodule
